// File: rtl/vertex_staging_regfile_if.sv
// Bus bundle for the vertex staging register file: the Avalon-MM slave port
// towards the CPU plus the triangle valid/ready port towards the rasteriser.
interface vertex_staging_regfile_if #(
  parameter int DATA_W    = 64,
  parameter int NUM_VERTS = 3,
  parameter int ADDR_W    = 3
);
  logic [ADDR_W-1:0]           address;
  logic                        write;
  logic                        read;
  logic [DATA_W-1:0]           writedata;
  logic [DATA_W/8-1:0]         byteenable;
  logic [DATA_W-1:0]           readdata;
  logic                        readdatavalid;
  logic [NUM_VERTS*DATA_W-1:0] tri_data;
  logic                        tri_valid;
  logic                        tri_ready;
  logic                        irq;

  // CPU and rasteriser side: drives requests and tri_ready
  modport master (
    output address, write, read, writedata, byteenable, tri_ready,
    input  readdata, readdatavalid, tri_data, tri_valid, irq
  );

  // Register file side
  modport slave (
    input  address, write, read, writedata, byteenable, tri_ready,
    output readdata, readdatavalid, tri_data, tri_valid, irq
  );
endinterface

// File: rtl/vertex_staging_regfile.sv
// Double-buffered vertex register file. The CPU fills a shadow bank and
// commits it with a submit command; the committed triangle is held in an
// active bank and offered to the rasteriser over valid/ready. One extra
// submission may be queued (FULL_PEND), during which the shadow bank is
// locked so the queued triangle cannot be disturbed.
module vertex_staging_regfile #(
  parameter int DATA_W    = 64,
  parameter int NUM_VERTS = 3,
  parameter int ADDR_W    = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  vertex_staging_regfile_if.slave   bus
);

  localparam int                VEC_W     = NUM_VERTS * DATA_W;
  localparam int                BE_W      = DATA_W / 8;
  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(NUM_VERTS);
  localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(NUM_VERTS + 1);

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_FULL      = 2'd1,
    ST_FULL_PEND = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [VEC_W-1:0]   r_shadow;
  logic [VEC_W-1:0]   r_active;
  logic               r_tri_valid;
  logic               r_overflow;
  logic               r_write_err;
  logic               r_irq;
  logic [7:0]         r_count;
  logic [DATA_W-1:0]  r_readdata;
  logic               r_readdatavalid;

  logic               w_vert_sel;
  logic               w_vert_wr;
  logic               w_locked;
  logic               w_vert_we;
  logic               w_set_werr;
  logic               w_ctrl_wr;
  logic               w_submit;
  logic               w_clr_sticky;
  logic               w_clr_irq;
  logic               w_handshake;
  logic               w_copy;
  logic               w_set_ovf;
  logic [15:0]        w_status;
  logic [DATA_W-1:0]  w_rd_data;

  // Address decode and command strobes
  assign w_vert_sel   = (bus.address < CTRL_ADDR);
  assign w_vert_wr    = bus.write & w_vert_sel;
  assign w_locked     = (r_state == ST_FULL_PEND);
  assign w_vert_we    = w_vert_wr & ~w_locked;
  assign w_set_werr   = w_vert_wr & w_locked;
  assign w_ctrl_wr    = bus.write & (bus.address == CTRL_ADDR) & bus.byteenable[0];
  assign w_submit     = w_ctrl_wr & bus.writedata[0];
  assign w_clr_sticky = w_ctrl_wr & bus.writedata[1];
  assign w_clr_irq    = w_ctrl_wr & bus.writedata[2];
  assign w_handshake  = r_tri_valid & bus.tri_ready;

  // Next-state logic: decides state moves, bank copies and overflow events
  always_comb begin
    w_next_state = r_state;
    w_copy       = 1'b0;
    w_set_ovf    = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_submit) begin
          w_copy       = 1'b1;
          w_next_state = ST_FULL;
        end else begin
          w_next_state = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_submit && w_handshake) begin
          w_copy       = 1'b1;
          w_next_state = ST_FULL;
        end else if (w_submit) begin
          w_next_state = ST_FULL_PEND;
        end else if (w_handshake) begin
          w_next_state = ST_EMPTY;
        end else begin
          w_next_state = ST_FULL;
        end
      end
      ST_FULL_PEND: begin
        // A submit here is dropped even if a handshake frees the slot.
        w_set_ovf = w_submit;
        if (w_handshake) begin
          w_copy       = 1'b1;
          w_next_state = ST_FULL;
        end else begin
          w_next_state = ST_FULL_PEND;
        end
      end
      default: begin
        w_next_state = ST_EMPTY;
      end
    endcase
  end

  // State register, active bank and the registered tri_valid
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_EMPTY;
      r_active    <= {VEC_W{1'b0}};
      r_tri_valid <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_tri_valid <= (w_next_state != ST_EMPTY);
      if (w_copy) begin
        // Takes the pre-write shadow; a same-cycle vertex write lands later.
        r_active <= r_shadow;
      end
    end
  end

  // Shadow bank: byte-masked vertex writes, blocked while a submit is queued
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_shadow <= {VEC_W{1'b0}};
    end else if (w_vert_we) begin
      for (int v = 0; v < NUM_VERTS; v++) begin
        for (int b = 0; b < BE_W; b++) begin
          if ((bus.address == ADDR_W'(v)) && bus.byteenable[b]) begin
            r_shadow[v*DATA_W + b*8 +: 8] <= bus.writedata[b*8 +: 8];
          end
        end
      end
    end
  end

  // Sticky error flags, irq and consumed counter; a set beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_overflow  <= 1'b0;
      r_write_err <= 1'b0;
      r_irq       <= 1'b0;
      r_count     <= 8'd0;
    end else begin
      if (w_set_ovf) begin
        r_overflow <= 1'b1;
      end else if (w_clr_sticky) begin
        r_overflow <= 1'b0;
      end
      if (w_set_werr) begin
        r_write_err <= 1'b1;
      end else if (w_clr_sticky) begin
        r_write_err <= 1'b0;
      end
      if (w_handshake) begin
        r_irq   <= 1'b1;
        r_count <= r_count + 8'd1;
      end else if (w_clr_irq) begin
        r_irq <= 1'b0;
      end
    end
  end

  // Read data mux: shadow vertices, STATUS, zero elsewhere
  always_comb begin
    w_status  = {r_count, 3'b000, r_irq, r_write_err, r_overflow, w_locked, r_tri_valid};
    w_rd_data = {DATA_W{1'b0}};
    for (int v = 0; v < NUM_VERTS; v++) begin
      w_rd_data = w_rd_data |
                  (r_shadow[v*DATA_W +: DATA_W] & {DATA_W{bus.address == ADDR_W'(v)}});
    end
    if (bus.address == STAT_ADDR) begin
      w_rd_data = DATA_W'(w_status);
    end else begin
      w_rd_data = w_rd_data & {DATA_W{w_vert_sel}};
    end
  end

  // Read port: latency one, readdata holds between reads
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_readdata      <= {DATA_W{1'b0}};
      r_readdatavalid <= 1'b0;
    end else begin
      r_readdatavalid <= bus.read;
      if (bus.read) begin
        r_readdata <= w_rd_data;
      end
    end
  end

  assign bus.readdata      = r_readdata;
  assign bus.readdatavalid = r_readdatavalid;
  assign bus.tri_data      = r_active;
  assign bus.tri_valid     = r_tri_valid;
  assign bus.irq           = r_irq;

endmodule

// File: tb/tb_vertex_staging_regfile.sv
// Directed bench for vertex_staging_regfile: byte-masked writes, submit paths,
// pending/overflow/lock behaviour, simultaneous events, counter wrap, reset.
module tb_vertex_staging_regfile;

  localparam int DATA_W    = 64;
  localparam int NUM_VERTS = 3;
  localparam int ADDR_W    = 3;

  logic clk;
  logic reset;
  int   n_asserts;
  int   n_fail;
  logic [63:0] rdat;

  vertex_staging_regfile_if #(.DATA_W(DATA_W), .NUM_VERTS(NUM_VERTS), .ADDR_W(ADDR_W)) bus ();

  vertex_staging_regfile #(.DATA_W(DATA_W), .NUM_VERTS(NUM_VERTS), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [63:0] d, input logic [7:0] be);
    bus.address    = a;
    bus.writedata  = d;
    bus.byteenable = be;
    bus.write      = 1'b1;
    tick();
    bus.write      = 1'b0;
    bus.byteenable = 8'h00;
  endtask

  task automatic rd(input logic [2:0] a, output logic [63:0] d);
    bus.address = a;
    bus.read    = 1'b1;
    tick();
    bus.read    = 1'b0;
    chk("readdatavalid", {191'd0, bus.readdatavalid}, 192'd1);
    d = bus.readdata;
  endtask

  task automatic hs();
    bus.tri_ready = 1'b1;
    tick();
    bus.tri_ready = 1'b0;
  endtask

  initial begin
    n_asserts      = 0;
    n_fail         = 0;
    reset          = 1'b0;
    bus.address    = 3'd0;
    bus.write      = 1'b0;
    bus.read       = 1'b0;
    bus.writedata  = 64'd0;
    bus.byteenable = 8'h00;
    bus.tri_ready  = 1'b0;

    // Reset state
    tick();
    chk("rst_tri_valid", {191'd0, bus.tri_valid}, 192'd0);
    chk("rst_tri_data", bus.tri_data, 192'd0);
    chk("rst_irq", {191'd0, bus.irq}, 192'd0);
    chk("rst_rdv", {191'd0, bus.readdatavalid}, 192'd0);
    chk("rst_readdata", {128'd0, bus.readdata}, 192'd0);
    tick();
    reset = 1'b1;
    tick();

    // Byte-masked write and readback
    wr(3'd1, 64'h1122334455667788, 8'h0F);
    rd(3'd1, rdat);
    chk("vert1_be", {128'd0, rdat}, {128'd0, 64'h0000000055667788});
    tick();
    chk("rdv_drops", {191'd0, bus.readdatavalid}, 192'd0);
    chk("readdata_holds", {128'd0, bus.readdata}, {128'd0, 64'h0000000055667788});
    rd(3'd5, rdat);
    chk("unmapped_read", {128'd0, rdat}, 192'd0);
    rd(3'd3, rdat);
    chk("ctrl_read", {128'd0, rdat}, 192'd0);

    // Submit from EMPTY, then consume
    wr(3'd0, 64'hA, 8'hFF);
    wr(3'd1, 64'hB, 8'hFF);
    wr(3'd2, 64'hC, 8'hFF);
    wr(3'd3, 64'h1, 8'h01);
    chk("submit_valid", {191'd0, bus.tri_valid}, 192'd1);
    chk("submit_data", bus.tri_data, {64'hC, 64'hB, 64'hA});
    rd(3'd4, rdat);
    chk("status_full", {128'd0, rdat}, {128'd0, 64'h0001});
    hs();
    chk("hs_valid_low", {191'd0, bus.tri_valid}, 192'd0);
    chk("hs_irq", {191'd0, bus.irq}, 192'd1);
    rd(3'd4, rdat);
    chk("status_cnt1", {128'd0, rdat}, {128'd0, 64'h0110});

    // Pending path
    wr(3'd3, 64'h4, 8'h01);
    chk("irq_cleared", {191'd0, bus.irq}, 192'd0);
    wr(3'd3, 64'h1, 8'h01);
    wr(3'd0, 64'h1111, 8'hFF);
    wr(3'd1, 64'h2222, 8'hFF);
    wr(3'd2, 64'h3333, 8'hFF);
    wr(3'd3, 64'h1, 8'h01);
    rd(3'd4, rdat);
    chk("status_pend", {128'd0, rdat}, {128'd0, 64'h0103});
    chk("pend_data_stable", bus.tri_data, {64'hC, 64'hB, 64'hA});
    wr(3'd0, 64'hDEAD, 8'hFF);
    rd(3'd4, rdat);
    chk("status_werr", {128'd0, rdat}, {128'd0, 64'h010B});
    rd(3'd0, rdat);
    chk("locked_vert0", {128'd0, rdat}, {128'd0, 64'h1111});
    wr(3'd3, 64'h1, 8'h01);
    rd(3'd4, rdat);
    chk("status_ovf", {128'd0, rdat}, {128'd0, 64'h010F});
    hs();
    chk("pend_hs_valid", {191'd0, bus.tri_valid}, 192'd1);
    chk("pend_hs_data", bus.tri_data, {64'h3333, 64'h2222, 64'h1111});
    rd(3'd4, rdat);
    chk("status_after_pend", {128'd0, rdat}, {128'd0, 64'h021D});
    wr(3'd3, 64'h6, 8'h01);
    rd(3'd4, rdat);
    chk("status_cleared", {128'd0, rdat}, {128'd0, 64'h0201});

    // Simultaneous submit and handshake in FULL
    wr(3'd0, 64'h44, 8'hFF);
    bus.tri_ready = 1'b1;
    wr(3'd3, 64'h1, 8'h01);
    bus.tri_ready = 1'b0;
    chk("sim_valid", {191'd0, bus.tri_valid}, 192'd1);
    chk("sim_data", bus.tri_data, {64'h3333, 64'h2222, 64'h44});
    rd(3'd4, rdat);
    chk("status_sim", {128'd0, rdat}, {128'd0, 64'h0311});

    // Clear-irq in a handshake cycle: set wins
    bus.tri_ready = 1'b1;
    wr(3'd3, 64'h4, 8'h01);
    bus.tri_ready = 1'b0;
    chk("clr_vs_set_irq", {191'd0, bus.irq}, 192'd1);
    chk("clr_hs_valid", {191'd0, bus.tri_valid}, 192'd0);
    rd(3'd4, rdat);
    chk("status_clr_hs", {128'd0, rdat}, {128'd0, 64'h0410});

    // Back-to-back submit with tri_ready held: 252 more handshakes wrap the count
    bus.address    = 3'd3;
    bus.writedata  = 64'h1;
    bus.byteenable = 8'h01;
    bus.write      = 1'b1;
    bus.tri_ready  = 1'b1;
    repeat (253) tick();
    bus.write      = 1'b0;
    bus.byteenable = 8'h00;
    bus.tri_ready  = 1'b0;
    chk("wrap_valid", {191'd0, bus.tri_valid}, 192'd1);
    rd(3'd4, rdat);
    chk("status_wrap", {128'd0, rdat}, {128'd0, 64'h0011});

    // Reset while pending and mid-handshake
    wr(3'd3, 64'h1, 8'h01);
    rd(3'd4, rdat);
    chk("status_pend2", {128'd0, rdat}, {128'd0, 64'h0013});
    reset         = 1'b0;
    bus.tri_ready = 1'b1;
    tick();
    reset         = 1'b1;
    bus.tri_ready = 1'b0;
    chk("rst2_tri_valid", {191'd0, bus.tri_valid}, 192'd0);
    chk("rst2_tri_data", bus.tri_data, 192'd0);
    chk("rst2_irq", {191'd0, bus.irq}, 192'd0);
    chk("rst2_readdata", {128'd0, bus.readdata}, 192'd0);
    rd(3'd4, rdat);
    chk("rst2_status", {128'd0, rdat}, 192'd0);
    for (int v = 0; v < NUM_VERTS; v++) begin
      rd(3'(v), rdat);
      chk("rst2_shadow", {128'd0, rdat}, 192'd0);
    end
    wr(3'd3, 64'h1, 8'h01);
    chk("rst2_submit_valid", {191'd0, bus.tri_valid}, 192'd1);
    chk("rst2_submit_data", bus.tri_data, 192'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/vertex_staging_regfile.md
# vertex_staging_regfile

Parametrised, double-buffered vertex register file on the GPU's Avalon-MM slave port. The CPU writes vertices into a shadow bank and commits them with a submit command. The committed triangle sits in an active bank and is offered to the rasteriser over a valid/ready handshake. Status readback, sticky error flags, a consumed-triangle counter and a completion interrupt let the CPU queue the next triangle while the current one is in flight.

## Interface
- DATA_W, 64: vertex word width in bits; must be a multiple of 8.
- NUM_VERTS, 3: vertices per primitive; must be at least 1.
- ADDR_W, 3: slave address width; must satisfy 2^ADDR_W ≥ NUM_VERTS+2.

- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- address  in  ADDR_W  word address.
- write  in  1  write strobe.
- read  in  1  read strobe.
- writedata  in  DATA_W  write data.
- byteenable  in  DATA_W/8  per-byte write enables.
- readdata  out  DATA_W  read data, registered.
- readdatavalid  out  1  high for exactly one cycle, one cycle after an accepted read.
- tri_data  out  NUM_VERTS*DATA_W  active bank; vertex i occupies bits [i*DATA_W +: DATA_W].
- tri_valid  out  1  active bank holds an unconsumed triangle.
- tri_ready  in  1  rasteriser accepts the triangle.
- irq  out  1  level interrupt: a triangle was consumed.

## Operation
- **Address map:**
  - 0..NUM_VERTS-1: shadow vertex registers (R/W).
  - NUM_VERTS: CTRL (W).
  - NUM_VERTS+1: STATUS (R).
  - Other addresses: reads return 0, writes are ignored.
- **Vertex writes:** update only the bytes whose byteenable bit is set. Vertex reads return the shadow bank, never the active bank.
- **CTRL write:** acted on only when byteenable[0]=1. Bits in writedata:
  - bit0 = submit.
  - bit1 = clear the overflow and write_err sticky flags.
  - bit2 = clear irq.
  - Bits may be combined in a single write.
- **CTRL read:** returns 0.
- **STATUS** (all other bits read 0):
  - bit0 = tri_valid.
  - bit1 = pending.
  - bit2 = overflow.
  - bit3 = write_err.
  - bit4 = irq.
  - [15:8] = consumed count, 8-bit, wraps 255→0.
- **State machine** (2 bits), with handshake = tri_valid & tri_ready:
  - **EMPTY** (tri_valid=0).
    - Submit: copy shadow→active, go to FULL.
  - **FULL** (tri_valid=1, pending=0).
    - Submit without handshake: go to FULL_PEND.
    - Submit with handshake in the same cycle: copy shadow→active, stay FULL.
    - Handshake alone: go to EMPTY.
  - **FULL_PEND** (tri_valid=1, pending=1).
    - Handshake: copy shadow→active, go to FULL.
    - Submit: set overflow; the command is dropped and the state is unchanged.
- **Copy semantics:** a copy captures the shadow contents before any same-cycle vertex write. The same-cycle write still lands in the shadow bank.
- **Shadow lock:** in FULL_PEND the shadow bank is locked. Vertex writes are ignored and set write_err.
- **Each handshake:**
  - increments the consumed count;
  - sets irq. If a CTRL clear-irq write arrives in the same cycle, the set wins.
- **Sticky clear vs. set:** if a clear (bit1) coincides with an event that sets overflow or write_err, the flag ends up set.
- **Read/write collision:** read and write in the same cycle is illegal master behaviour; the write is performed and the read returns pre-write data.

## Timing
- **Reset values** (every output and register, on the first rising edge with reset=0):
  - readdata=0, readdatavalid=0, tri_valid=0, tri_data=0, irq=0.
  - Shadow bank 0, count 0, both sticky flags 0, state EMPTY.
- Reset asserted mid-handshake or while pending discards everything; the pending submission is lost.
- **Writes:** zero wait states; effect visible on the next cycle.
- **Reads:** fixed latency 1. readdata and readdatavalid are registered in the cycle after read=1. readdata holds its value when readdatavalid=0.
- **Submit accepted at edge N:**
  - tri_valid=1 and new tri_data from cycle N+1.
  - A STATUS read issued at cycle N+1 reflects the new state.
- **tri_data** is stable whenever tri_valid=1 until a handshake occurs.
- **Handshake at edge N:**
  - FULL_PEND: new active data at N+1, tri_valid stays 1.
  - FULL: tri_valid=0 at N+1.
- **Throughput:** one triangle per cycle is sustainable (submit every cycle with tri_ready held at 1).

## Test plan
- **Byteenable write and readback:** after reset, write vertex 1 = 0x1122334455667788 with byteenable=0x0F, then read vertex 1 → 0x0000000055667788, readdatavalid one cycle later; read address NUM_VERTS+2 → 0.
- **Submit from EMPTY:** write vertices 0..2 = 0xA, 0xB, 0xC, then write CTRL=1 → next cycle tri_valid=1 and tri_data = {0xC, 0xB, 0xA}. Then pulse tri_ready → tri_valid=0, irq=1, STATUS[15:8]=1.
- **Pending path:** submit triangle A with tri_ready=0, write new vertices for B, submit again → STATUS=0x03. Then:
  - write vertex 0 → ignored, write_err set;
  - extra submit → overflow set;
  - tri_ready=1 for one cycle → tri_data=B next cycle, pending=0;
  - CTRL=6 → STATUS bits 2..4 clear.
- **Simultaneous events:** in FULL, drive submit and tri_ready in the same cycle → data replaced, tri_valid stays 1, count+1. Also drive a clear-irq write in a handshake cycle → irq remains 1.
- **Counter wrap and reset mid-operation:** perform 256 handshakes → count reads 0. Then assert reset while in FULL_PEND → all outputs 0, state EMPTY, shadow bank reads 0.
